// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with same-cycle push+pop (top replace), occupancy count and
// overflow/underflow pulses. Optional sticky error flags under macro STACK_STICKY_ERR_EN.
module lifo_stack_param #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
`ifdef STACK_STICKY_ERR_EN
  ,
  input  logic                         err_clr,
  output logic                         ovf_sticky,
  output logic                         udf_sticky
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] top_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] rd_data;

  // Entry that becomes top after a pop; only consumed when count >= 2.
  assign rd_data = mem[AW'(count - CW'(2))];

  // Operation decode and next-state computation.
  always_comb begin
    state_nxt = state_q;
    count_nxt = count;
    top_nxt   = top;
    ovf_nxt   = 1'b0;
    udf_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;

    case ({push, pop})
      2'b10: begin
        if (state_q == ST_FULL) begin
          ovf_nxt = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = AW'(count);
          top_nxt   = din;
          count_nxt = count + CW'(1);
        end
      end
      2'b01: begin
        if (state_q == ST_EMPTY) begin
          udf_nxt = 1'b1;
        end else begin
          count_nxt = count - CW'(1);
          top_nxt   = (count >= CW'(2)) ? rd_data : '0;
        end
      end
      2'b11: begin
        if (state_q == ST_EMPTY) begin
          // Nothing to replace: behaves as a push, but the pop half is flagged.
          udf_nxt   = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = '0;
          top_nxt   = din;
          count_nxt = CW'(1);
        end else begin
          wr_en   = 1'b1;
          wr_addr = AW'(count - CW'(1));
          top_nxt = din;
        end
      end
      default: begin
      end
    endcase

    if (count_nxt == '0) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == CW'(DEPTH)) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_PARTIAL;
    end
  end

  // State, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      count     <= '0;
      top       <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      count     <= count_nxt;
      top       <= top_nxt;
      full      <= (state_nxt == ST_FULL);
      empty     <= (state_nxt == ST_EMPTY);
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

`ifdef STACK_STICKY_ERR_EN
  // Sticky flags: a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (ovf_nxt) begin
        ovf_sticky <= 1'b1;
      end else if (err_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (udf_nxt) begin
        udf_sticky <= 1'b1;
      end else if (err_clr) begin
        udf_sticky <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param: directed scenarios plus random traffic against a queue model.
module tb_lifo_stack_param;

  localparam int unsigned SW  = 8;
  localparam int unsigned SD  = 4;
  localparam int unsigned BW  = 2;
  localparam int unsigned BD  = 256;
  localparam int unsigned SCW = $clog2(SD + 1);
  localparam int unsigned BCW = $clog2(BD + 1);

  logic           clk;
  logic           rst_n;

  logic           push, pop;
  logic [SW-1:0]  din, top;
  logic           full, empty, overflow, underflow;
  logic [SCW-1:0] count;

  logic           push2, pop2;
  logic [BW-1:0]  din2, top2;
  logic           full2, empty2, overflow2, underflow2;
  logic [BCW-1:0] count2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] q  [$];
  logic [BW-1:0] q2 [$];
  logic          exp_ovf, exp_udf;

  lifo_stack_param #(.WIDTH(SW), .DEPTH(SD)) u_small (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .top(top),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  lifo_stack_param #(.WIDTH(BW), .DEPTH(BD)) u_big (
    .clk(clk), .rst_n(rst_n), .push(push2), .pop(pop2), .din(din2), .top(top2),
    .full(full2), .empty(empty2), .count(count2), .overflow(overflow2), .underflow(underflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_small(input string tag);
    logic [SW-1:0] et;
    et = (q.size() != 0) ? q[q.size()-1] : '0;
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".top"}, 32'(top), 32'(et));
    check({tag, ".full"}, 32'(full), 32'(q.size() == SD));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".udf"}, 32'(underflow), 32'(exp_udf));
  endtask

  task automatic check_big(input string tag);
    logic [BW-1:0] et;
    et = (q2.size() != 0) ? q2[q2.size()-1] : '0;
    check({tag, ".count"}, 32'(count2), 32'(q2.size()));
    check({tag, ".top"}, 32'(top2), 32'(et));
    check({tag, ".full"}, 32'(full2), 32'(q2.size() == BD));
    check({tag, ".empty"}, 32'(empty2), 32'(q2.size() == 0));
    check({tag, ".ovf"}, 32'(overflow2), 32'(exp_ovf));
    check({tag, ".udf"}, 32'(underflow2), 32'(exp_udf));
  endtask

  // One clock of the small stack: apply inputs, advance the model, check after the edge.
  task automatic step(input string tag, input logic p, input logic po, input logic [SW-1:0] d);
    push = p; pop = po; din = d;
    exp_ovf = 1'b0; exp_udf = 1'b0;
    if (p && !po) begin
      if (q.size() == SD) exp_ovf = 1'b1;
      else q.push_back(d);
    end else if (!p && po) begin
      if (q.size() == 0) exp_udf = 1'b1;
      else void'(q.pop_back());
    end else if (p && po) begin
      if (q.size() == 0) begin
        exp_udf = 1'b1;
        q.push_back(d);
      end else begin
        q[q.size()-1] = d;
      end
    end
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    check_small(tag);
  endtask

  task automatic step_big(input string tag, input logic p, input logic po,
                          input logic [BW-1:0] d, input bit do_check);
    push2 = p; pop2 = po; din2 = d;
    exp_ovf = 1'b0; exp_udf = 1'b0;
    if (p && !po) begin
      if (q2.size() == BD) exp_ovf = 1'b1;
      else q2.push_back(d);
    end else if (!p && po) begin
      if (q2.size() == 0) exp_udf = 1'b1;
      else void'(q2.pop_back());
    end
    @(posedge clk); #1;
    push2 = 1'b0; pop2 = 1'b0;
    if (do_check) check_big(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    push = 1'b0; pop = 1'b0; din = '0;
    push2 = 1'b0; pop2 = 1'b0; din2 = '0;
    exp_ovf = 1'b0; exp_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_small("reset");
    check_big("reset_big");
    #3 rst_n = 1'b1;

    // Fill to full, then one rejected push.
    step("push1", 1'b1, 1'b0, 8'h11);
    step("push2", 1'b1, 1'b0, 8'h22);
    step("push3", 1'b1, 1'b0, 8'h33);
    step("push4", 1'b1, 1'b0, 8'h44);
    step("push5_ovf", 1'b1, 1'b0, 8'h55);
    check("push5_top_const", 32'(top), 32'h44);
    step("idle_after_ovf", 1'b0, 1'b0, 8'h00);

    // Drain, then one rejected pop.
    step("pop1", 1'b0, 1'b1, 8'h00);
    check("pop1_top_const", 32'(top), 32'h33);
    step("pop2", 1'b0, 1'b1, 8'h00);
    step("pop3", 1'b0, 1'b1, 8'h00);
    step("pop4", 1'b0, 1'b1, 8'h00);
    step("pop5_udf", 1'b0, 1'b1, 8'h00);
    step("idle_after_udf", 1'b0, 1'b0, 8'hxx);

    // Top replace.
    step("pa0", 1'b1, 1'b0, 8'hA0);
    step("pa1", 1'b1, 1'b0, 8'hA1);
    step("replace", 1'b1, 1'b1, 8'hB7);
    check("replace_top_const", 32'(top), 32'hB7);
    step("pop_after_replace", 1'b0, 1'b1, 8'h00);
    check("pop_after_replace_const", 32'(top), 32'hA0);
    step("fill_a", 1'b1, 1'b0, 8'hC1);
    step("fill_b", 1'b1, 1'b0, 8'hC2);
    step("fill_c", 1'b1, 1'b0, 8'hC3);
    step("replace_full", 1'b1, 1'b1, 8'hD4);
    step("replace_full2", 1'b1, 1'b1, 8'hD5);

    // Drain and push+pop on empty.
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 8'h00);
    step("pp_empty", 1'b1, 1'b1, 8'h5A);
    step("pp_empty_idle", 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-cycle.
    step("r_push1", 1'b1, 1'b0, 8'h01);
    step("r_push2", 1'b1, 1'b0, 8'h02);
    #2 rst_n = 1'b0;
    q.delete(); q2.delete();
    exp_ovf = 1'b0; exp_udf = 1'b0;
    #1;
    check_small("async_reset");
    #2 rst_n = 1'b1;
    step("after_reset_push", 1'b1, 1'b0, 8'h77);
    check("after_reset_top_const", 32'(top), 32'h77);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      step("rand", op[1], op[0], 8'($urandom));
    end
    while (q.size() != 0) step("rand_drain", 1'b0, 1'b1, 8'h00);

    // Deep stack: fill past capacity, then unwind.
    for (int i = 0; i < BD; i++) begin
      step_big("big_fill", 1'b1, 1'b0, 2'($urandom), (i < 3) || (i > BD - 3));
    end
    check("big_count_256", 32'(count2), 32'd256);
    step_big("big_ovf", 1'b1, 1'b0, 2'($urandom), 1'b1);
    for (int i = 0; i < BD; i++) begin
      step_big("big_pop", 1'b0, 1'b1, 2'b00, 1'b1);
    end
    step_big("big_udf", 1'b0, 1'b1, 2'b00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
